// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver shared definitions:
// seven-segment codes and seg bit order.
package seg_pkg;

    // seg bit order, all active-low
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
        logic dp;
    } seg_t;

    // a..g patterns, 0 = segment lit
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver bus: datapath-side inputs
// and display-pin outputs.
interface seg_scan_driver_if #(
    parameter int DIGITS = 8
);

    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     digit_en;
    logic                  hex_mode;
    logic                  lz_blank;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output load,
        output value,
        output dp,
        output digit_en,
        output hex_mode,
        output lz_blank,
        input  seg,
        input  an
    );

    modport slave (
        input  load,
        input  value,
        input  dp,
        input  digit_en,
        input  hex_mode,
        input  lz_blank,
        output seg,
        output an
    );

endinterface

// File: rtl/seg_scan_driver_decode.sv
// hex_seg_decode: nibble to active-low a..g,
// purely combinational.
module hex_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] segs
);

    // full 16-entry hex lookup
    always_comb begin
        segs = SEG_OFF;
        unique case (nib)
            4'h0: segs = SEG_0;
            4'h1: segs = SEG_1;
            4'h2: segs = SEG_2;
            4'h3: segs = SEG_3;
            4'h4: segs = SEG_4;
            4'h5: segs = SEG_5;
            4'h6: segs = SEG_6;
            4'h7: segs = SEG_7;
            4'h8: segs = SEG_8;
            4'h9: segs = SEG_9;
            4'hA: segs = SEG_A;
            4'hB: segs = SEG_B;
            4'hC: segs = SEG_C;
            4'hD: segs = SEG_D;
            4'hE: segs = SEG_E;
            4'hF: segs = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-anode
// seven-segment scanner with shadowed data.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);

    logic [PW-1:0]        pre;
    logic [IW-1:0]        idx;
    logic [4*DIGITS-1:0]  sh_val;
    logic [DIGITS-1:0]    sh_dp;
    logic [DIGITS-1:0]    sh_en;
    logic [DIGITS-1:0]    lz;
    logic                 zero_run;
    logic [3:0]           nib;
    logic                 cur_dp;
    logic                 cur_en;
    logic                 cur_lz;
    logic [6:0]           dec;
    logic                 blank;
    seg_t                 seg_nxt;
    logic [DIGITS-1:0]    an_nxt;
    logic [7:0]           seg_q;
    logic [DIGITS-1:0]    an_q;

    // prescaler; digit index steps on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_TOP) begin
            pre <= '0;
            idx <= (idx == IDX_TOP) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // shadow copies change only on load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val <= '0;
            sh_dp  <= '0;
            sh_en  <= '0;
        end else if (bus.load) begin
            sh_val <= bus.value;
            sh_dp  <= bus.dp;
            sh_en  <= bus.digit_en;
        end
    end

    // digit i is a leading zero when it and
    // every digit above it are zero; digit 0
    // is always shown
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run
                     & (sh_val[4*i +: 4] == 4'h0);
            lz[i]    = zero_run & (i != 0);
        end
    end

    // pick the active digit's data and anode
    always_comb begin
        nib    = 4'h0;
        cur_dp = 1'b0;
        cur_en = 1'b0;
        cur_lz = 1'b0;
        an_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = sh_val[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_en    = sh_en[i];
                cur_lz    = lz[i];
                an_nxt[i] = 1'b0;
            end
        end
    end

    hex_seg_decode u_dec (
        .nib  (nib),
        .segs (dec)
    );

    // segment pattern, guard slot forced dark
    always_comb begin
        blank = !cur_en
              | (!bus.hex_mode & (nib > 4'd9))
              | (bus.lz_blank & cur_lz);
        seg_nxt = {blank ? SEG_OFF : dec,
                   ~(cur_en & cur_dp)};
        if (pre == '0) begin
            seg_nxt = SEG_BLANK;
        end
    end

    // registered pins; anodes dark in guard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= seg_nxt;
            an_q  <= (pre == '0) ? '1 : an_nxt;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed checks of scan
// timing, decode, blanking and shadow loads.
module tb_seg_scan_driver;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;

    seg_scan_driver_if #(.DIGITS(8)) bus ();

    seg_scan_driver #(
        .DIGITS (8),
        .DIV    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scan position after posedge number cyc
    function automatic int mpre();
        return (cyc - 1) % 4;
    endfunction

    function automatic int midx();
        return ((cyc - 1) / 4) % 8;
    endfunction

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h",
                   tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic goto_slot(input int d,
                             input int p);
        int n;
        n = 0;
        tick();
        while (!(midx() == d && mpre() == p)
               && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $error("FAIL goto got=%0d exp=%0d",
                   midx(), d);
        end
    endtask

    task automatic show(input string tag,
                        input int d,
                        input logic [7:0] exp);
        logic [7:0] ea;
        goto_slot(d, 1);
        ea = ~(8'd1 << d);
        chk({tag, "_an"}, bus.an, ea);
        chk({tag, "_seg"}, bus.seg, exp);
    endtask

    task automatic do_load(input logic [31:0] v,
                           input logic [7:0] d,
                           input logic [7:0] e);
        bus.value    = v;
        bus.dp       = d;
        bus.digit_en = e;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    initial begin
        logic [7:0] ea;
        tests        = 0;
        fails        = 0;
        cyc          = 0;
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dp       = '0;
        bus.digit_en = '0;
        bus.hex_mode = 1'b0;
        bus.lz_blank = 1'b0;

        #12;
        chk("rst_seg", bus.seg, 8'hFF);
        chk("rst_an", bus.an, 8'hFF);

        tick();
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        chk("rel_c1_an", bus.an, 8'hFF);
        tick();
        chk("rel_c2_an", bus.an, 8'hFE);
        chk("rel_c2_seg", bus.seg, 8'hFF);

        // full hex scan
        bus.hex_mode = 1'b1;
        do_load(32'h89ABCDEF, 8'h00, 8'hFF);
        for (int k = 0; k < 32; k++) begin
            tick();
            if (mpre() == 0) begin
                ea = 8'hFF;
                chk("guard_seg", bus.seg, 8'hFF);
            end else begin
                ea = ~(8'd1 << midx());
            end
            chk("frame_an", bus.an, ea);
        end
        show("hex_d0", 0, 8'b0111000_1);
        show("hex_d4", 4, 8'b1100000_1);
        show("hex_d7", 7, 8'b0000000_1);

        // BCD mode and dp
        bus.hex_mode = 1'b0;
        do_load(32'h0000001A, 8'h02, 8'hFF);
        show("bcd_d0", 0, 8'hFF);
        show("bcd_d1", 1, 8'b1001111_0);
        show("bcd_d2", 2, 8'b0000001_1);

        // leading-zero blanking
        bus.lz_blank = 1'b1;
        do_load(32'h00000305, 8'h00, 8'hFF);
        show("lz_d7", 7, 8'hFF);
        show("lz_d3", 3, 8'hFF);
        show("lz_d2", 2, 8'b0000110_1);
        show("lz_d1", 1, 8'b0000001_1);
        show("lz_d0", 0, 8'b0100100_1);
        do_load(32'h00000000, 8'h00, 8'hFF);
        show("zero_d1", 1, 8'hFF);
        show("zero_d0", 0, 8'b0000001_1);

        // value change without load
        bus.value = 32'h00000007;
        show("noload_d0", 0, 8'b0000001_1);

        // load on the wrap edge into digit 3
        goto_slot(2, 2);
        bus.value    = 32'h76543210;
        bus.digit_en = 8'hFF;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
        tick();
        chk("coll_guard_an", bus.an, 8'hFF);
        tick();
        chk("coll_an", bus.an, 8'hF7);
        chk("coll_seg", bus.seg, 8'b0000110_1);

        // enable mask forces dp off too
        bus.lz_blank = 1'b0;
        do_load(32'h76543210, 8'hFF, 8'h0F);
        show("en_d7", 7, 8'hFF);
        show("en_d5", 5, 8'hFF);
        show("en_d4", 4, 8'hFF);
        show("en_d3", 3, 8'b0000110_0);
        show("en_d0", 0, 8'b0000001_0);

        // asynchronous reset mid-frame
        goto_slot(5, 2);
        chk("pre_rst_an", bus.an, 8'hDF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_seg", bus.seg, 8'hFF);
        chk("async_an", bus.an, 8'hFF);
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        chk("rel2_c1_an", bus.an, 8'hFF);
        tick();
        chk("rel2_c2_an", bus.an, 8'hFE);
        chk("rel2_c2_seg", bus.seg, 8'hFF);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
